db_reg_serializer: RTL and testbench



---
 rtl/db_reg_serializer.sv | 127 ++++++++++++
 tb/tb_db_reg_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/db_reg_serializer.sv
// Serialises each new 4-bit debug code as a UART-style frame on db_tx.
// Optional even parity bit after d3 when DB_SERIALIZER_PARITY_EN is defined.
module db_reg_serializer #(
  parameter int CLK_DIV     = 16,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [3:0]             db_reg,
  output logic                   db_tx,
  output logic                   db_busy,
  output logic [3:0]             db_sent,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef DB_SERIALIZER_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             bit_q, bit_d;
  logic [3:0]             shift_q, shift_d;
  logic [3:0]             sent_q, sent_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   bit_end;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sent_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sent_q  <= sent_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    sent_d  = sent_q;
    fcnt_d  = fcnt_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        // Only the value present at the idle compare is sent; values seen mid-frame are dropped
        if (db_reg != sent_q) begin
          state_d = START;
          shift_d = db_reg;
          sent_d  = db_reg;
          fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[3:1]};
          if (bit_q == 2'd3) begin
`ifdef DB_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end
      end
`ifdef DB_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    db_tx   = 1'b1;
    db_busy = (state_q != IDLE);
    case (state_q)
      IDLE:   db_tx = 1'b1;
      START:  db_tx = 1'b0;
      DATA:   db_tx = shift_q[0];
`ifdef DB_SERIALIZER_PARITY_EN
      PARITY: db_tx = ^sent_q;
`endif
      STOP:   db_tx = 1'b1;
      default: db_tx = 1'b1;
    endcase
  end

  assign db_sent   = sent_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_db_reg_serializer.sv
// Scoreboard bench for db_reg_serializer: frame-level reference model feeds an
// expectation queue, a line monitor decodes db_tx cycle by cycle and compares.
module tb_db_reg_serializer;

  localparam int CLK_DIV = 4;
  localparam int FW      = 4;
`ifdef DB_SERIALIZER_PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  localparam int FRAME_LEN = NBITS * CLK_DIV;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [3:0]    db_reg = 4'h0;
  logic          db_tx;
  logic          db_busy;
  logic [3:0]    db_sent;
  logic [FW-1:0] frame_cnt;

  db_reg_serializer #(.CLK_DIV(CLK_DIV), .FRAME_CNT_W(FW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .db_reg(db_reg),
    .db_tx(db_tx), .db_busy(db_busy), .db_sent(db_sent), .frame_cnt(frame_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0]    val;
    logic [FW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expected line level c cycles into a frame carrying v
  function automatic logic exp_bit(input int c, input logic [3:0] v);
    int idx;
    idx = c / CLK_DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 4) return v[idx-1];
`ifdef DB_SERIALIZER_PARITY_EN
    if (idx == 5) return ^v;
`endif
    return 1'b1;
  endfunction

  // Reference model: a frame occupies FRAME_LEN cycles after its trigger edge,
  // the following edge is an idle compare against the last sent value.
  logic [3:0]    m_sent = 4'h0;
  logic [FW-1:0] m_cnt = '0;
  int            m_busy_left = 0;

  initial begin
    forever begin
      @(posedge HCLK);
      if (HRESET) begin
        m_sent = 4'h0;
        m_cnt = '0;
        m_busy_left = 0;
        exp_q.delete();
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (db_reg != m_sent) begin
        exp_t e;
        m_sent = db_reg;
        m_cnt = m_cnt + 1'b1;
        e.val = db_reg;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        m_busy_left = FRAME_LEN;
      end
    end
  end

  // Line monitor
  logic aborted;
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) continue;
      if (!db_busy) begin
        chk("idle_tx", db_tx, 1'b1);
      end else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: got frame with db_sent=%0h, expected none at %0t", db_sent, $time);
        for (int k = 0; k < FRAME_LEN && db_busy; k++) @(negedge HCLK);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_db_sent", db_sent, e.val);
        chk("frame_cnt", frame_cnt, e.cnt);
        aborted = 1'b0;
        for (int c = 0; c < FRAME_LEN; c++) begin
          if (c > 0) @(negedge HCLK);
          if (HRESET) begin
            aborted = 1'b1;
            break;
          end
          chk("frame_tx", db_tx, exp_bit(c, e.val));
          chk("frame_busy", db_busy, 1'b1);
        end
        if (!aborted) begin
          @(negedge HCLK);
          if (!HRESET) begin
            chk("gap_busy", db_busy, 1'b0);
            chk("gap_tx", db_tx, 1'b1);
          end
        end
      end
    end
  end

  task automatic wait_busy(input int limit);
    int n;
    n = 0;
    while (!db_busy && n < limit) begin
      @(negedge HCLK);
      n++;
    end
    if (!db_busy) timeout_fail("wait_busy");
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (db_busy && n < limit) begin
      @(negedge HCLK);
      n++;
    end
    if (db_busy) timeout_fail("wait_idle");
  endtask

  initial begin
    int blen;
    logic [3:0] seq [6];
    seq = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h7};

    // Reset values and quiet line with db_reg held at zero
    #1;
    chk("rst_tx", db_tx, 1'b1);
    chk("rst_busy", db_busy, 1'b0);
    chk("rst_sent", db_sent, 4'h0);
    chk("rst_cnt", frame_cnt, '0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (200) @(negedge HCLK);
    chk("quiet_cnt", frame_cnt, '0);
    chk("quiet_busy", db_busy, 1'b0);

    // First frame, with mid-frame changes that must be coalesced
    db_reg = 4'hA;
    @(negedge HCLK);
    chk("latency_tx", db_tx, 1'b0);
    blen = 0;
    while (db_busy && blen < 100) begin
      blen++;
      if (blen == 5)  db_reg = 4'h3;
      if (blen == 10) db_reg = 4'h5;
      if (blen == 15) db_reg = 4'h6;
      if (blen == 18) db_reg = 4'h5;
      @(negedge HCLK);
    end
    chk("busy_len", blen, FRAME_LEN);
    @(negedge HCLK);
    chk("refire_after_gap", db_busy, 1'b1);
    chk("refire_sent", db_sent, 4'h5);
    wait_idle(FRAME_LEN + 4);
    chk("after_coalesce_cnt", frame_cnt, FW'(2));

    // Reset in the middle of data bit 2
    @(negedge HCLK);
    db_reg = 4'hA;
    wait_busy(8);
    repeat (13) @(negedge HCLK);
    @(posedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    chk("abort_tx", db_tx, 1'b1);
    chk("abort_busy", db_busy, 1'b0);
    repeat (3) @(negedge HCLK);
    chk("abort_cnt", frame_cnt, '0);
    HRESET = 1'b0;
    wait_busy(8);
    chk("restart_cnt", frame_cnt, FW'(1));
    chk("restart_sent", db_sent, 4'hA);
    wait_idle(FRAME_LEN + 4);

    // Alternating values, each after idle, then a parity-sensitive code
    foreach (seq[i]) begin
      @(negedge HCLK);
      db_reg = seq[i];
      wait_busy(8);
      wait_idle(FRAME_LEN + 4);
    end

    // Random traffic, long enough to wrap the frame counter repeatedly
    for (int i = 0; i < 500; i++) begin
      db_reg = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 40)) @(negedge HCLK);
    end

    repeat (2 * FRAME_LEN + 4) @(negedge HCLK);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_idle", db_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
